max_pool_2x2: RTL
=================

Name: max_pool_2x2

Overview:
- 2x2, stride-2 max-pooling stage sitting directly downstream of the ReLU stage in the VGG datapath.
- Consumes the ReLU's 4-lane signed 8-bit stream: 4 channels of one pixel per beat, pixels in row-major raster order.
- Emits one 4-lane pooled pixel per 2x2 window.
- No backpressure, matching the valid-only upstream interface.

Parameters:
- IMG_W, 224: feature-map width in pixels; must be even and >= 2.
- IMG_H, 224: feature-map height in pixels; must be even and >= 2.
- DW, 8: lane data width (signed).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous active-high reset.
- data_i_1..data_i_4  input  DW each  signed channel lanes 1-4 of the current input pixel.
- valid_i  input  1  input beat valid.
- data_o_1..data_o_4  output  DW each  signed pooled lanes 1-4 (registered).
- valid_o  output  1  pooled-pixel valid (registered).
- frame_done_o  output  1  one-cycle pulse coincident with the last valid_o of a frame.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - data_o_1..4 = 0, valid_o = 0, frame_done_o = 0.
  - col counter and row counter = 0; pair register = 0.
  - Line-buffer contents are not reset and need not be.
- Counters:
  - col (0..IMG_W-1) and row (0..IMG_H-1) advance only on valid_i=1.
  - col wraps IMG_W-1 -> 0 and increments row.
  - row wraps IMG_H-1 -> 0; the next frame starts immediately with no gap required.
- valid_i=0 cycles: all state is held; valid_o=0 and frame_done_o=0 that cycle; data_o holds its last value.
- Even col (col[0]=0): per lane, the pair register captures the input.
- Odd col: per lane, hmax = signed max(pair register, input); ties select either (values are equal).
- Even row, odd col: line buffer entry [col>>1] <= hmax for all 4 lanes; no output.
- Odd row, odd col:
  - data_o_k <= signed max(hmax_k, linebuf[col>>1]_k).
  - valid_o <= 1 on the next edge; latency is 1 cycle from the completing beat (bottom-right pixel of the window).
- frame_done_o <= 1 together with valid_o when row=IMG_H-1 and col=IMG_W-1.
- Comparison is signed two's-complement, so negative inputs are handled correctly; with ReLU upstream all inputs are >= 0.
- Line buffer:
  - IMG_W/2 entries x 4*DW bits; one write (even row) or one read (odd row) per beat, never both.
  - Register or RAM; if synchronous-read RAM is used, the read address is issued on the even-col beat so 1-cycle output latency is preserved.
- Throughput:
  - One input beat per cycle sustained.
  - Outputs per frame = (IMG_W/2)*(IMG_H/2), each at most every other cycle.
- Reset mid-frame:
  - Partial window discarded; counters return to 0; no valid_o is produced for the aborted frame.
  - The next valid_i is treated as pixel (0,0).

Test Plan:
- Bench overrides IMG_W=4, IMG_H=4 for scenarios 1-4.
- 1. Single frame, back-to-back: lane1 pixel(r,c) = 4r+c (0..15), lanes 2-4 = lane1+1, +2, +3.
  - Required: valid_o exactly 4 times, lane1 = 5, 7, 13, 15 in that order; lanes 2-4 offset by +1/+2/+3.
  - Each valid_o occurs 1 cycle after the beats for pixels 5, 7, 13, 15.
  - frame_done_o with the last output only.
- 2. Same frame with valid_i toggling 1,0,1,0,...
  - Required: identical outputs and order; valid_o never asserts during an idle input cycle's response slot; data_o holds between outputs.
- 3. Window-position test: all pixels 0 except a single 127 placed in turn at each of the 4 positions of window 0 (one frame each).
  - Required: first output lane1 = 127 every time; the other 3 outputs = 0.
- 4. Signed compare: a window containing -128, -1, -5, -100 on all lanes.
  - Required: output -1 (0xFF) on all lanes.
- 5. rst asserted after 6 beats of frame 1, then a full frame sent.
  - Required: no valid_o from the aborted frame; after reset, outputs exactly as in scenario 1.
- 6. Default parameters, 2 consecutive frames with no gap, random 0..127 data.
  - Required: 12544 valid_o per frame, matching a reference-model max; frame_done_o exactly twice.

Source files
------------

// File: rtl/max_pool_2x2.sv
// max_pool_2x2
// 2x2, stride-2 max-pooling stage for a 4-lane signed pixel stream arriving
// in row-major raster order (one pixel = 4 channels per beat, valid-only).
// Emits one pooled 4-lane pixel per 2x2 window, one cycle after the beat
// that completes the window (its bottom-right pixel).
//
// Ports:
//   clk                  rising-edge clock
//   rst                  synchronous active-high reset
//   data_i_1..data_i_4   signed input lanes of the current pixel
//   valid_i              input beat valid
//   data_o_1..data_o_4   signed pooled lanes (registered, held between outputs)
//   valid_o              pooled-pixel valid (registered)
//   frame_done_o         pulse with the last valid_o of a frame
module max_pool_2x2 #(
  parameter int IMG_W = 224,
  parameter int IMG_H = 224,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] data_i_1,
  input  logic [DW-1:0] data_i_2,
  input  logic [DW-1:0] data_i_3,
  input  logic [DW-1:0] data_i_4,
  input  logic          valid_i,
  output logic [DW-1:0] data_o_1,
  output logic [DW-1:0] data_o_2,
  output logic [DW-1:0] data_o_3,
  output logic [DW-1:0] data_o_4,
  output logic          valid_o,
  output logic          frame_done_o
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int LB_D  = IMG_W / 2;
  localparam int LB_AW = (LB_D > 1) ? $clog2(LB_D) : 1;

  typedef logic [3:0][DW-1:0] pix_t;

  function automatic logic [DW-1:0] smax(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  pix_t             pair_q, pair_d;
  pix_t             data_o_q, data_o_d;
  logic             valid_o_q, valid_o_d;
  logic             frame_done_q, frame_done_d;

  pix_t             din;
  pix_t             hmax;
  pix_t             lb_rdata;
  logic             lb_we;
  logic [LB_AW-1:0] lb_addr;
  logic             col_last, row_last;

  // One entry per horizontal pair: holds the top-row pair maxima until the
  // odd row arrives. Contents are never reset; every entry is written on an
  // even row before it is read on the following odd row.
  pix_t linebuf_q [LB_D];

  assign din      = {data_i_4, data_i_3, data_i_2, data_i_1};
  assign lb_addr  = LB_AW'(col_q >> 1);
  assign lb_rdata = linebuf_q[lb_addr];
  assign col_last = (col_q == COL_W'(IMG_W - 1));
  assign row_last = (row_q == ROW_W'(IMG_H - 1));

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      hmax[k] = smax(pair_q[k], din[k]);
    end
  end

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    pair_d       = pair_q;
    data_o_d     = data_o_q;
    valid_o_d    = 1'b0;
    frame_done_d = 1'b0;
    lb_we        = 1'b0;

    if (valid_i) begin
      if (!col_q[0]) begin
        pair_d = din;
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
        // Bottom-right pixel of a window: combine with the stored top pair.
        for (int k = 0; k < 4; k++) begin
          data_o_d[k] = smax(hmax[k], lb_rdata[k]);
        end
        valid_o_d    = 1'b1;
        frame_done_d = row_last && col_last;
      end

      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      pair_q       <= '0;
      data_o_q     <= '0;
      valid_o_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      pair_q       <= pair_d;
      data_o_q     <= data_o_d;
      valid_o_q    <= valid_o_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (lb_we) begin
      linebuf_q[lb_addr] <= hmax;
    end
  end

  assign data_o_1     = data_o_q[0];
  assign data_o_2     = data_o_q[1];
  assign data_o_3     = data_o_q[2];
  assign data_o_4     = data_o_q[3];
  assign valid_o      = valid_o_q;
  assign frame_done_o = frame_done_q;

endmodule
